// File: rtl/hpdl1414_chain_driver.sv
// Byte-stream driver for a chain of HPDL-1414 displays: decodes characters into a
// cursor-addressed buffer and pushes only changed positions out with programmable bus timing.
module hpdl1414_chain_driver #(
    parameter int unsigned NUM_DISP     = 4,
    parameter int unsigned SCROLL       = 0,
    parameter int unsigned SETUP_CYCLES = 2,
    parameter int unsigned WR_CYCLES    = 2,
    parameter int unsigned HOLD_CYCLES  = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [7:0]          in_data,
    output logic                in_ready,
    output logic [6:0]          hpdl_d,
    output logic [1:0]          hpdl_a,
    output logic [NUM_DISP-1:0] hpdl_wr_n,
    output logic                idle
);

    localparam int unsigned N    = NUM_DISP * 4;
    localparam int unsigned PW   = $clog2(N + 1);
    localparam int unsigned SW   = $clog2(N);
    localparam int unsigned MAXA = (SETUP_CYCLES > WR_CYCLES) ? SETUP_CYCLES : WR_CYCLES;
    localparam int unsigned MAXC = (MAXA > HOLD_CYCLES) ? MAXA : HOLD_CYCLES;
    localparam int unsigned CW   = $clog2(MAXC + 1);

    typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StHold} state_e;

    logic [6:0]    char_q [N];
    logic [6:0]    char_d [N];
    logic [N-1:0]  dirty_q;
    logic [N-1:0]  dirty_set;
    logic [N-1:0]  dirty_clr;
    logic [PW-1:0] cursor_q;
    logic [PW-1:0] cursor_d;
    logic [SW-1:0] scan_q;
    logic [SW-1:0] pos_q;
    logic [CW-1:0] cnt_q;
    state_e        state_q;
    logic          is_print;
    logic [6:0]    ch;
    logic          latch;

    assign is_print = ~in_data[7] & (|in_data[6:5]);
    // Lowercase 0x60-0x7F folds onto 0x40-0x5F.
    assign ch       = (in_data[6:5] == 2'b11) ? {2'b10, in_data[4:0]} : in_data[6:0];

    always_comb begin
        char_d    = char_q;
        dirty_set = '0;
        cursor_d  = cursor_q;
        if (in_valid && in_ready) begin
            if (is_print) begin
                if (cursor_q == PW'(N)) begin
                    // Cursor parked past the end only in scroll mode: shift left, append.
                    for (int i = 0; i < N - 1; i++) begin
                        char_d[i] = char_q[i+1];
                    end
                    char_d[N-1] = ch;
                    dirty_set   = '1;
                end else begin
                    for (int i = 0; i < N; i++) begin
                        if (cursor_q == PW'(i)) begin
                            char_d[i]    = ch;
                            dirty_set[i] = 1'b1;
                        end
                    end
                    if (SCROLL == 0 && cursor_q == PW'(N - 1)) begin
                        cursor_d = '0;
                    end else begin
                        cursor_d = cursor_q + PW'(1);
                    end
                end
            end else if (in_data == 8'h08) begin
                if (cursor_q != '0) begin
                    cursor_d = cursor_q - PW'(1);
                    for (int i = 0; i < N; i++) begin
                        if (cursor_q == PW'(i + 1)) begin
                            char_d[i]    = 7'h20;
                            dirty_set[i] = 1'b1;
                        end
                    end
                end
            end else if (in_data == 8'h0D) begin
                cursor_d = '0;
            end else if (in_data == 8'h0C) begin
                for (int i = 0; i < N; i++) begin
                    char_d[i] = 7'h20;
                end
                dirty_set = '1;
                cursor_d  = '0;
            end
        end
    end

    assign latch     = (state_q == StIdle) && dirty_q[scan_q];
    assign dirty_clr = latch ? (N'(1) << scan_q) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                char_q[i] <= 7'h20;
            end
            dirty_q  <= '1;
            cursor_q <= '0;
            in_ready <= 1'b0;
        end else begin
            char_q   <= char_d;
            // A new byte for the position being latched keeps it dirty.
            dirty_q  <= (dirty_q & ~dirty_clr) | dirty_set;
            cursor_q <= cursor_d;
            in_ready <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            scan_q    <= '0;
            pos_q     <= '0;
            cnt_q     <= '0;
            hpdl_d    <= '0;
            hpdl_a    <= '0;
            hpdl_wr_n <= '1;
            idle      <= 1'b0;
        end else begin
            idle <= (state_q == StIdle) && (dirty_q == '0);
            unique case (state_q)
                StIdle: begin
                    scan_q <= (scan_q == SW'(N - 1)) ? '0 : scan_q + SW'(1);
                    if (latch) begin
                        pos_q   <= scan_q;
                        hpdl_a  <= ~scan_q[1:0];
                        hpdl_d  <= char_q[scan_q];
                        cnt_q   <= CW'(SETUP_CYCLES - 1);
                        state_q <= StSetup;
                    end
                end
                StSetup: begin
                    if (cnt_q == '0) begin
                        hpdl_wr_n <= ~(NUM_DISP'(1) << (pos_q >> 2));
                        cnt_q     <= CW'(WR_CYCLES - 1);
                        state_q   <= StStrobe;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                StStrobe: begin
                    if (cnt_q == '0) begin
                        hpdl_wr_n <= '1;
                        cnt_q     <= CW'(HOLD_CYCLES - 1);
                        state_q   <= StHold;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                StHold: begin
                    if (cnt_q == '0) begin
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_hpdl1414_chain_driver.sv
// Drives a wrap-mode and a scroll-mode driver with the same byte stream and checks the
// resulting display contents and bus timing against a character-buffer reference model.
module tb_hpdl1414_chain_driver;

    localparam int N     = 16;
    localparam int SETUP = 2;
    localparam int WR    = 2;
    localparam int HOLD  = 1;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data  = 8'h00;
    logic       in_ready [2];
    logic [6:0] hd       [2];
    logic [1:0] ha       [2];
    logic [3:0] wr_n     [2];
    logic       idle     [2];

    hpdl1414_chain_driver #(.NUM_DISP(4), .SCROLL(0), .SETUP_CYCLES(SETUP), .WR_CYCLES(WR),
                            .HOLD_CYCLES(HOLD)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready[0]), .hpdl_d(hd[0]), .hpdl_a(ha[0]), .hpdl_wr_n(wr_n[0]),
        .idle(idle[0])
    );
    hpdl1414_chain_driver #(.NUM_DISP(4), .SCROLL(1), .SETUP_CYCLES(SETUP), .WR_CYCLES(WR),
                            .HOLD_CYCLES(HOLD)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready[1]), .hpdl_d(hd[1]), .hpdl_a(ha[1]), .hpdl_wr_n(wr_n[1]),
        .idle(idle[1])
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: character buffer and cursor per mode (index = SCROLL value).
    logic [6:0] mbuf [2][N];
    int         mcur [2];

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int p = 0; p < N; p++) mbuf[m][p] = 7'h20;
            mcur[m] = 0;
        end
    endtask

    task automatic model_byte(input int m, input logic [7:0] b);
        logic [7:0] c;
        if (b >= 8'h20 && b <= 8'h7F) begin
            c = (b >= 8'h60) ? b - 8'h20 : b;
            if (mcur[m] < N) begin
                mbuf[m][mcur[m]] = c[6:0];
                mcur[m]++;
                if (m == 0 && mcur[m] == N) mcur[m] = 0;
            end else begin
                for (int i = 0; i < N - 1; i++) mbuf[m][i] = mbuf[m][i+1];
                mbuf[m][N-1] = c[6:0];
            end
        end else if (b == 8'h08) begin
            if (mcur[m] > 0) begin
                mcur[m]--;
                mbuf[m][mcur[m]] = 7'h20;
            end
        end else if (b == 8'h0D) begin
            mcur[m] = 0;
        end else if (b == 8'h0C) begin
            for (int p = 0; p < N; p++) mbuf[m][p] = 7'h20;
            mcur[m] = 0;
        end
    endtask

    // What the physical displays show, plus a log of every completed write.
    logic [6:0] dmem [2][N];
    int         log0 [$];
    int         log1 [$];
    logic [3:0] prev_wr    [2];
    logic [8:0] prev_bus   [2];
    int         stable     [2];
    int         low_len    [2];
    int         since_rise [2];

    always @(negedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (!rst_n) begin
                prev_wr[m]    = 4'hF;
                prev_bus[m]   = {ha[m], hd[m]};
                stable[m]     = 0;
                low_len[m]    = 0;
                since_rise[m] = 1000;
            end else begin
                logic chg;
                int   disp;
                int   ent;
                chg = ({ha[m], hd[m]} != prev_bus[m]);
                stable[m] = chg ? 0 : stable[m] + 1;
                if (since_rise[m] < 1000) since_rise[m]++;
                if (wr_n[m] != 4'hF) begin
                    check("strobe_onehot", $countones(~wr_n[m]), 1);
                    check("bus_stable_in_strobe", chg, 0);
                    if (prev_wr[m] == 4'hF) begin
                        check("setup_time", stable[m] >= SETUP, 1);
                        low_len[m] = 1;
                    end else begin
                        low_len[m]++;
                    end
                end else if (prev_wr[m] != 4'hF) begin
                    check("strobe_width", low_len[m], WR);
                    disp = 0;
                    for (int k = 0; k < 4; k++) if (!prev_wr[m][k]) disp = k;
                    dmem[m][disp*4 + 3 - int'(prev_bus[m][8:7])] = prev_bus[m][6:0];
                    ent = disp*4096 + int'(prev_bus[m][8:7])*256 + int'(prev_bus[m][6:0]);
                    if (m == 0) log0.push_back(ent); else log1.push_back(ent);
                    since_rise[m] = 0;
                end else if (since_rise[m] <= HOLD) begin
                    check("hold_time", chg, 0);
                end
                prev_wr[m]  = wr_n[m];
                prev_bus[m] = {ha[m], hd[m]};
            end
        end
    end

    function automatic int log_size(input int m);
        return (m == 0) ? log0.size() : log1.size();
    endfunction

    function automatic int log_at(input int m, input int i);
        return (m == 0) ? log0[i] : log1[i];
    endfunction

    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        model_byte(0, b);
        model_byte(1, b);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        repeat (3) @(negedge clk);
        n = 0;
        while (!(idle[0] && idle[1]) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle"}, {31'b0, idle[0] & idle[1]}, 1);
    endtask

    task automatic compare(input string tag);
        for (int m = 0; m < 2; m++)
            for (int p = 0; p < N; p++)
                check($sformatf("%s_m%0d_p%0d", tag, m, p), dmem[m][p], mbuf[m][p]);
    endtask

    task automatic check_blank_log(input string tag);
        for (int m = 0; m < 2; m++) begin
            check($sformatf("%s_count_m%0d", tag, m), log_size(m), 16);
            for (int i = 0; i < 16 && i < log_size(m); i++)
                check($sformatf("%s_w%0d_m%0d", tag, i, m), log_at(m, i),
                      (i / 4) * 4096 + (3 - i % 4) * 256 + 32'h20);
        end
    endtask

    task automatic check_coverage(input string tag);
        for (int m = 0; m < 2; m++)
            for (int p = 0; p < N; p++) begin
                int found;
                found = 0;
                for (int i = 0; i < log_size(m); i++)
                    if ((log_at(m, i) / 4096) * 4 + 3 - (log_at(m, i) / 256) % 16 == p) found = 1;
                check($sformatf("%s_m%0d_p%0d", tag, m, p), found, 1);
            end
    endtask

    task automatic clear_logs();
        log0.delete();
        log1.delete();
    endtask

    initial begin
        string s;
        int    n;
        model_reset();
        for (int m = 0; m < 2; m++) for (int p = 0; p < N; p++) dmem[m][p] = 7'h00;

        #2 rst_n = 1'b0;
        #1;
        for (int m = 0; m < 2; m++) begin
            check("rst_wr_n", wr_n[m], 4'hF);
            check("rst_d", hd[m], 0);
            check("rst_a", ha[m], 0);
            check("rst_idle", idle[m], 0);
            check("rst_ready", in_ready[m], 0);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int m = 0; m < 2; m++) check("ready_after_rst", in_ready[m], 1);
        wait_idle("boot");
        check_blank_log("boot");
        compare("boot");

        clear_logs();
        send(8'h41);
        wait_idle("char_a");
        for (int m = 0; m < 2; m++) begin
            check("char_a_count", log_size(m), 1);
            if (log_size(m) > 0) check("char_a_write", log_at(m, 0), 3 * 256 + 32'h41);
        end
        compare("char_a");

        clear_logs();
        send(8'h0D);
        send(8'h61);
        send(8'h08);
        send(8'h08);
        wait_idle("bksp");
        for (int m = 0; m < 2; m++)
            if (log_size(m) > 0)
                check("bksp_last_write", log_at(m, log_size(m) - 1), 3 * 256 + 32'h20);
            else
                check("bksp_write_count", log_size(m), 1);
        compare("bksp");
        // Cursor must be back at 0: the next character lands on position 0.
        send(8'h58);
        wait_idle("bksp_cursor");
        compare("bksp_cursor");

        send(8'h0C);
        wait_idle("ff1");
        compare("ff1");
        clear_logs();
        s = "ABCDEFGHIJKLMNOPQ";
        for (int i = 0; i < 17; i++) send(8'(s[i]));
        wait_idle("str17");
        compare("str17");
        check("wrap_pos0", dmem[0][0], 7'h51);
        check("scroll_pos0", dmem[1][0], 7'h42);
        check("scroll_pos15", dmem[1][15], 7'h51);
        check_coverage("str17_cov");
        send(8'h5A);
        wait_idle("cursor17");
        check("wrap_cursor1", dmem[0][1], 7'h5A);
        check("scroll_cursor16", dmem[1][15], 7'h5A);
        compare("cursor17");
        send(8'h0C);
        wait_idle("ff2");
        compare("ff2");

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 40; i++) begin
                int k;
                k = $urandom_range(0, 9);
                if (k < 6) send(8'($urandom_range(32, 127)));
                else if (k == 6) send(8'h08);
                else if (k == 7) send(8'h0D);
                else if (k == 8) send(8'($urandom_range(0, 255)));
                else repeat ($urandom_range(1, 12)) @(negedge clk);
            end
            wait_idle($sformatf("rand%0d", r));
            compare($sformatf("rand%0d", r));
        end

        send(8'h42);
        n = 0;
        while (wr_n[0] == 4'hF && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("strobe_seen", wr_n[0] != 4'hF, 1);
        #2 rst_n = 1'b0;
        clear_logs();
        #1;
        for (int m = 0; m < 2; m++) begin
            check("midrst_wr_n", wr_n[m], 4'hF);
            check("midrst_ready", in_ready[m], 0);
        end
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_idle("reboot");
        check_blank_log("reboot");
        compare("reboot");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hpdl1414_chain_driver.md
# hpdl1414_chain_driver

Parametrised driver for a chain of HPDL-1414 four-character alphanumeric displays sharing one data/address bus with one active-low write strobe per display. It accepts a byte stream (from the UART receiver) on a valid/ready handshake, interprets printable characters and a small set of control codes into a character buffer with a cursor, and a write engine pushes only changed positions to the displays with programmable setup/strobe/hold timing. It sits between the UART receiver and the display pins in the top-level wrapper.

## Interface

- NUM_DISP, 4, number of HPDL-1414 displays; buffer holds NUM_DISP*4 characters (N).
- SCROLL, 0, 0 = cursor wraps to position 0 after the last position; 1 = text scrolls left when the buffer is full.
- SETUP_CYCLES, 2, clocks data/address are stable before the strobe (min 1).
- WR_CYCLES, 2, clocks the strobe is held low (min 1).
- HOLD_CYCLES, 1, clocks data/address are held after the strobe rises (min 1).

- clk  in  1  system clock (12 MHz).
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  byte available.
- in_data  in  8  byte from UART receiver.
- in_ready  out  1  byte accepted when in_valid & in_ready.
- hpdl_d  out  7  display data D6..D0.
- hpdl_a  out  2  display digit address A1..A0.
- hpdl_wr_n  out  NUM_DISP  per-display write strobe, active low; bit k = display k (leftmost = 0).
- idle  out  1  high when no position is dirty and the engine is in IDLE.

## Operation

- Buffer position p (0 = leftmost character): display p/4, address 3 - (p mod 4) (HPDL digit 0 is rightmost).
- in_ready is 1 whenever out of reset; one byte is processed per accepted cycle, effect visible in the buffer the next cycle.
- Byte decode (cursor c):
  - 0x20-0x5F: buf[c] = byte[6:0]; dirty[c] set; cursor advances.
  - 0x60-0x7F: mapped to byte - 0x20 (uppercase), then as above.
  - 0x08 backspace: if c > 0, c = c-1, buf[c] = 0x20, dirty set; at c = 0 no effect.
  - 0x0D CR: c = 0, buffer unchanged.
  - 0x0C FF: all positions = 0x20, all dirty, c = 0.
  - 0x80-0xFF and other controls: ignored.
- Cursor advance, SCROLL=0: range 0..N-1; after N-1 goes to 0.
- SCROLL=1: range 0..N; writing at c < N advances normally (may reach N); printable at c = N shifts buffer left by one (buf[i] = buf[i+1]), writes char at N-1, marks all positions dirty, c stays N. Backspace at N goes to N-1 and blanks N-1.
- Write engine FSM: IDLE, SETUP, STROBE, HOLD.
  - IDLE: examine scan_ptr each cycle; if dirty[scan_ptr], latch position and buf value, clear that dirty bit, go SETUP; scan_ptr increments (wraps N-1 -> 0) every IDLE cycle.
  - SETUP: drive hpdl_a/hpdl_d, all strobes high, SETUP_CYCLES clocks.
  - STROBE: selected hpdl_wr_n bit low, WR_CYCLES clocks.
  - HOLD: all strobes high, bus held, HOLD_CYCLES clocks, then IDLE.
- Simultaneous dirty clear (engine latch) and dirty set (new byte, same position): set wins; position is rewritten later with the new value. The in-flight write uses the latched value.
- hpdl_d/hpdl_a keep last driven value while IDLE.

## Timing

- Reset (async, immediate): hpdl_wr_n all 1, hpdl_d = 0, hpdl_a = 0, idle = 0, in_ready = 0 while rst_n low; buffer all 0x20, all dirty, cursor 0, scan_ptr 0, state IDLE. After release, in_ready = 1 next edge and the engine blanks all N positions.
- Reset mid-strobe: strobe returns high asynchronously; no glitch low afterwards until a full SETUP completes.
- Write cycle length SETUP_CYCLES + WR_CYCLES + HOLD_CYCLES + 1 (IDLE detect) clocks.
- Byte accepted at edge t: dirty at t+1; SETUP entered at most N cycles after the engine returns to IDLE.
- idle updates registered, one cycle after the condition holds.
- Only one hpdl_wr_n bit may be low at any time; strobe never low in SETUP/HOLD/IDLE.

## Test plan

- Reset release, NUM_DISP=4: exactly 16 strobes, each with hpdl_d = 0x20, addresses 3,2,1,0 per display 0..3; then idle = 1.
- Send 0x41 after idle: one write, hpdl_wr_n = 4'b1110, hpdl_a = 3, hpdl_d = 0x41; strobe low exactly WR_CYCLES, data stable SETUP_CYCLES before and HOLD_CYCLES after.
- Send 0x61, 0x08, 0x08: buffer[0] = 0x20, cursor 0; second backspace no effect; last write to position 0 is 0x20.
- SCROLL=0, send 17 bytes "ABCDEFGHIJKLMNOPQ": position 0 holds 'Q', cursor 1; 0x0C then blanks all 16.
- SCROLL=1, send 17 bytes same string: positions 0..15 = "BCDEFGHIJKLMNOPQ", all 16 rewritten, cursor 16.
- Assert rst_n low during STROBE: hpdl_wr_n = all 1 without waiting for clk; after release, full blanking sequence repeats.
